sram_fill_engine: RTL and testbench
===================================

SRAM_FILL_ENGINE -- requirements
Module: sram_fill_engine

Interface
REQ-001 SHALL provide parameter ADDR_W, default 15, SRAM word address width.
REQ-002 SHALL provide parameter DATA_W, default 32, SRAM data width.
REQ-003 SHALL provide parameter RD_LAT, default 1, SRAM read latency in cycles (legal 1..4).
REQ-004 SHALL provide port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port start  input  1  level request; rising into IDLE begins an operation.
REQ-007 SHALL provide port abort  input  1  terminate the current operation.
REQ-008 SHALL provide port mode  input  2  fill pattern: 0 constant, 1 address-as-data, 2 incrementing from pattern, 3 inverted constant.
REQ-009 SHALL provide port verify  input  1  read back and compare after the write pass.
REQ-010 SHALL provide port start_addr / end_addr  input  ADDR_W each  inclusive fill range.
REQ-011 SHALL provide port pattern  input  DATA_W  seed or constant data.
REQ-012 SHALL provide ports addr (output, ADDR_W), en (output, 1), wr (output, 1), wdata (output, DATA_W), rdata (input, DATA_W) as the SRAM port.
REQ-013 SHALL provide ports busy, done, err (output, 1 each) and err_addr (output, ADDR_W) as status.

Function
REQ-014 SHALL implement states IDLE, WR, RD, DRAIN, DONE.
REQ-015 In IDLE with start=1, SHALL latch mode, verify, start_addr, end_addr and pattern, then enter WR. Later input changes SHALL be ignored until the next IDLE.
REQ-016 If latched end_addr < start_addr, SHALL go IDLE->DONE with no SRAM access and err=0.
REQ-017 In WR, SHALL drive en=1, wr=1, and walk addr from start_addr to end_addr, one word per cycle.
REQ-018 wdata SHALL be a function of the current addr:
- mode 0: pattern
- mode 1: addr zero-extended (truncated if ADDR_W>DATA_W)
- mode 2: pattern + (addr - start_addr), modulo 2^DATA_W
- mode 3: ~pattern
REQ-019 After writing end_addr, SHALL enter RD if verify=1, else DONE.
REQ-020 In RD, SHALL drive en=1, wr=0, and walk addr start_addr..end_addr, one per cycle; after end_addr SHALL enter DRAIN.
REQ-021 In RD, SHALL delay the expected data and address by RD_LAT cycles and compare against rdata on the returning cycle.
REQ-022 DRAIN SHALL last exactly RD_LAT cycles with en=0, so every outstanding read is compared; it then SHALL enter DONE.
REQ-023 On the first mismatch, SHALL set err=1 and capture err_addr. Later mismatches SHALL NOT change err_addr.
REQ-024 In DONE, done=1; SHALL stay in DONE while start=1 and return to IDLE when start=0.
REQ-025 busy SHALL be 1 in WR, RD and DRAIN, and 0 otherwise.
REQ-026 en SHALL be 0 in IDLE, DRAIN and DONE. wr SHALL be 0 whenever en=0.
REQ-027 abort=1 in any state SHALL force IDLE on the next edge, with en=0 and done never asserted; err and err_addr SHALL be cleared.
REQ-028 abort has priority over start when both are high.
REQ-029 The addr counter SHALL hold at end_addr, never wrap. A full range 0..2^ADDR_W-1 SHALL complete without overflow.
REQ-030 Total latency from start to done: 1 + N cycles with verify=0, or 1 + 2N + RD_LAT cycles with verify=1, where N = end_addr - start_addr + 1.
REQ-031 err and err_addr SHALL clear on entry to WR from IDLE and SHALL be held through DONE.

Reset
REQ-032 On reset=1 at a clock edge, SHALL set state to IDLE and set addr, en, wr, busy, done, err and err_addr to 0. wdata SHALL be 0 in IDLE.
REQ-033 Reset asserted mid-operation SHALL abandon the operation within one cycle with no further SRAM access. The operation SHALL NOT resume after reset deasserts, even if start remains 1; the block SHALL wait for start to go low and rise again.

Verification
REQ-034 mode 0, pattern 0, range 0..0x7FFF, verify=0 -> 32768 writes of 0, then done=1 at cycle 32769 after start.
REQ-035 mode 2, pattern 0xFFFFFFFE, range 0x10..0x13, verify=1, model returns written data -> wdata FFFFFFFE, FFFFFFFF, 0, 1; err=0; done after 1+8+RD_LAT cycles.
REQ-036 verify=1 with the model corrupting address 0x12 -> err=1 and err_addr=0x12, with RD_LAT swept over 1..4.
REQ-037 start_addr=0x20, end_addr=0x1F -> done on the next cycle, en never 1.
REQ-038 abort at the 5th write cycle, then start held high -> state IDLE, en=0, done=0, and the block does not restart until start toggles low then high.
REQ-039 reset=1 during RD -> all outputs 0 on the next cycle; start kept at 1 does not resume the operation.

Source files
------------

// File: rtl/sram_fill_engine_if.sv
// rtl/sram_fill_engine_if.sv - control, status and SRAM port bundle for the fill engine
interface sram_fill_engine_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic              verify;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [DATA_W-1:0] pattern;
  logic [ADDR_W-1:0] addr;
  logic              en;
  logic              wr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] err_addr;

  modport master (
    input  start, abort, mode, verify, start_addr, end_addr, pattern, rdata,
    output addr, en, wr, wdata, busy, done, err, err_addr
  );

  modport slave (
    output start, abort, mode, verify, start_addr, end_addr, pattern, rdata,
    input  addr, en, wr, wdata, busy, done, err, err_addr
  );
endinterface

// File: rtl/sram_fill_engine.sv
// rtl/sram_fill_engine.sv - SRAM pattern fill with optional read-back compare
module sram_fill_engine #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic                clk,
  input logic                reset,
  sram_fill_engine_if.master bus
);
  typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q;
  logic              verify_q;
  logic [ADDR_W-1:0] start_q, end_q, addr_q, err_addr_q;
  logic [DATA_W-1:0] pat_q;
  logic              armed_q, err_q;
  logic [2:0]        drain_q;
  logic              pv_q [RD_LAT];
  logic [DATA_W-1:0] pd_q [RD_LAT];
  logic [ADDR_W-1:0] pa_q [RD_LAT];
  logic              accept, at_end, mismatch;
  logic [DATA_W-1:0] fill_data;

  // armed_q demands start be seen low before a new operation, so a start held
  // across reset or abort never relaunches one.
  assign accept   = (state_q == IDLE) && bus.start && armed_q && !bus.abort;
  assign at_end   = (addr_q == end_q);
  assign mismatch = pv_q[RD_LAT-1] && (bus.rdata != pd_q[RD_LAT-1]);

  always_comb begin
    fill_data = pat_q;
    case (mode_q)
      2'd0:    fill_data = pat_q;
      2'd1:    fill_data = DATA_W'(addr_q);
      2'd2:    fill_data = pat_q + DATA_W'(addr_q - start_q);
      default: fill_data = ~pat_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (bus.end_addr < bus.start_addr) ? DONE : WR;
      WR:      if (at_end) state_d = verify_q ? RD : DONE;
      RD:      if (at_end) state_d = DRAIN;
      DRAIN:   if (drain_q == 3'(RD_LAT - 1)) state_d = DONE;
      DONE:    if (!bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= 2'd0;
      verify_q   <= 1'b0;
      start_q    <= '0;
      end_q      <= '0;
      pat_q      <= '0;
      addr_q     <= '0;
      armed_q    <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      drain_q    <= 3'd0;
      for (int k = 0; k < RD_LAT; k++) begin
        pv_q[k] <= 1'b0;
        pd_q[k] <= '0;
        pa_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == DRAIN) ? drain_q + 3'd1 : 3'd0;
      // Expected data and address ride alongside the read until rdata returns.
      pv_q[0] <= (state_q == RD) && !bus.abort;
      pd_q[0] <= fill_data;
      pa_q[0] <= addr_q;
      for (int k = 1; k < RD_LAT; k++) begin
        pv_q[k] <= pv_q[k-1] && !bus.abort;
        pd_q[k] <= pd_q[k-1];
        pa_q[k] <= pa_q[k-1];
      end
      if (bus.abort) begin
        armed_q    <= 1'b0;
        err_q      <= 1'b0;
        err_addr_q <= '0;
      end else if (accept) begin
        mode_q     <= bus.mode;
        verify_q   <= bus.verify;
        start_q    <= bus.start_addr;
        end_q      <= bus.end_addr;
        pat_q      <= bus.pattern;
        addr_q     <= bus.start_addr;
        armed_q    <= 1'b0;
        err_q      <= 1'b0;
        err_addr_q <= '0;
      end else begin
        if (!bus.start) armed_q <= 1'b1;
        if (mismatch && !err_q) begin
          err_q      <= 1'b1;
          err_addr_q <= pa_q[RD_LAT-1];
        end
        // Compare before increment so the walk stops at end_addr without wrapping.
        if (state_q == WR) begin
          if (!at_end)       addr_q <= addr_q + ADDR_W'(1);
          else if (verify_q) addr_q <= start_q;
        end else if (state_q == RD && !at_end) begin
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
    end
  end

  assign bus.en       = (state_q == WR) || (state_q == RD);
  assign bus.wr       = (state_q == WR);
  assign bus.busy     = (state_q == WR) || (state_q == RD) || (state_q == DRAIN);
  assign bus.done     = (state_q == DONE);
  assign bus.addr     = addr_q;
  assign bus.wdata    = (state_q == WR) ? fill_data : '0;
  assign bus.err      = err_q;
  assign bus.err_addr = err_addr_q;
endmodule

// File: tb/tb_sram_fill_engine.sv
// tb/tb_sram_fill_engine.sv - bench running four read latencies side by side against an SRAM model
module tb_sram_fill_engine;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, abort, verify, corrupt_en;
  logic [1:0]    mode;
  logic [AW-1:0] sa, ea, c_lo, c_hi, peek_addr;
  logic [DW-1:0] pattern;

  wire [NI-1:0]    en_v, wr_v, busy_v, done_v, err_v;
  wire [NI*AW-1:0] addr_v, err_addr_v;
  wire [NI*DW-1:0] wdata_v, peek_v;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NI; g++) begin : lane
    localparam int LAT = g + 1;
    sram_fill_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rpipe [LAT];
    logic [DW-1:0] rd_word;

    assign bus.start      = start;
    assign bus.abort      = abort;
    assign bus.mode       = mode;
    assign bus.verify     = verify;
    assign bus.start_addr = sa;
    assign bus.end_addr   = ea;
    assign bus.pattern    = pattern;
    assign rd_word = mem[bus.addr] ^ {{(DW-1){1'b0}},
                     corrupt_en && (bus.addr == c_lo || bus.addr == c_hi)};
    always @(posedge clk) begin
      if (bus.en && bus.wr) mem[bus.addr] <= bus.wdata;
      rpipe[0] <= rd_word;
      for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign bus.rdata = rpipe[LAT-1];

    assign en_v[g]                 = bus.en;
    assign wr_v[g]                 = bus.wr;
    assign busy_v[g]               = bus.busy;
    assign done_v[g]               = bus.done;
    assign err_v[g]                = bus.err;
    assign addr_v[g*AW +: AW]      = bus.addr;
    assign err_addr_v[g*AW +: AW]  = bus.err_addr;
    assign wdata_v[g*DW +: DW]     = bus.wdata;
    assign peek_v[g*DW +: DW]      = mem[peek_addr];

    sram_fill_engine #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
    );
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_word(input logic [1:0] m, input logic [DW-1:0] p,
                                             input int s, input int a);
    case (m)
      2'd0:    return p;
      2'd1:    return DW'(a);
      2'd2:    return p + DW'(a - s);
      default: return ~p;
    endcase
  endfunction

  task automatic run_op(input string name, input logic [1:0] m, input logic v, input int s,
                        input int e, input logic [DW-1:0] p, input logic ce, input int lo,
                        input int hi);
    int  first_done[NI];
    int  bad[NI];
    int  n, exp_ea, lat;
    bit  exp_err, en_any;
    mode = m; verify = v; sa = AW'(s); ea = AW'(e); pattern = p;
    corrupt_en = ce; c_lo = AW'(lo); c_hi = AW'(hi);
    n = (e >= s) ? e - s + 1 : 0;
    exp_err = 1'b0; exp_ea = 0;
    if (ce && v && n > 0) begin
      if (lo >= s && lo <= e) begin exp_err = 1'b1; exp_ea = lo; end
      if (hi >= s && hi <= e && (!exp_err || hi < exp_ea)) begin exp_err = 1'b1; exp_ea = hi; end
    end
    foreach (first_done[g]) begin first_done[g] = 0; bad[g] = 0; end
    en_any = 1'b0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 2 * n + 16; cyc++) begin
      step();
      en_any |= |en_v;
      for (int g = 0; g < NI; g++)
        if (done_v[g] && first_done[g] == 0) first_done[g] = cyc;
      if (cyc == 1) begin
        if (n > 0) begin
          chk({name, "_wr_first"}, wr_v, {NI{1'b1}});
          chk({name, "_err_clr"}, err_v, '0);
        end
        mode = 2'($urandom); verify = ~verify; sa = AW'($urandom); ea = AW'($urandom);
        pattern = $urandom;
      end
      if (&done_v) break;
    end
    chk({name, "_en_any"}, en_any, n > 0);
    for (int g = 0; g < NI; g++) begin
      lat = (n == 0) ? 1 : (v ? 1 + 2 * n + g + 1 : 1 + n);
      chk($sformatf("%s_lat%0d_done_cyc", name, g + 1), first_done[g], lat);
      chk($sformatf("%s_lat%0d_err", name, g + 1), err_v[g], exp_err);
      chk($sformatf("%s_lat%0d_err_addr", name, g + 1), err_addr_v[g*AW +: AW], exp_ea);
    end
    chk({name, "_idle_bus"}, {busy_v, en_v}, '0);
    if (n > 0) begin
      for (int a = s; a <= e; a++) begin
        peek_addr = AW'(a);
        #1;
        for (int g = 0; g < NI; g++)
          if (peek_v[g*DW +: DW] !== exp_word(m, p, s, a)) bad[g]++;
      end
      for (int g = 0; g < NI; g++) chk($sformatf("%s_lat%0d_mem", name, g + 1), bad[g], 0);
      step();
    end
    chk({name, "_done_hold"}, done_v, {NI{1'b1}});
    start = 1'b0;
    step();
    chk({name, "_back_idle"}, {done_v, busy_v}, '0);
  endtask

  initial begin
    int  s, len;
    bit  en_any, done_any;
    reset = 1'b1; start = 1'b0; abort = 1'b0; verify = 1'b0; mode = 2'd0;
    sa = '0; ea = '0; pattern = '0; corrupt_en = 1'b0; c_lo = '0; c_hi = '0; peek_addr = '0;
    repeat (3) step();
    chk("rst_ctl", {en_v, wr_v, busy_v, done_v, err_v}, '0);
    chk("rst_addr", {addr_v, err_addr_v}, '0);
    chk("rst_wdata", wdata_v, '0);
    reset = 1'b0;
    step();

    run_op("inc_wrap", 2'd2, 1'b1, 'h10, 'h13, 32'hFFFF_FFFE, 1'b0, 0, 0);
    run_op("bad12", 2'd0, 1'b1, 'h10, 'h13, 32'hA5A5_0000, 1'b1, 'h12, 'h12);
    run_op("two_bad", 2'd1, 1'b1, 'h20, 'h2F, 32'h0, 1'b1, 'h25, 'h21);

    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_clr_err", {err_v, err_addr_v}, '0);
    step();

    run_op("empty", 2'd0, 1'b1, 'h20, 'h1F, 32'h1234_5678, 1'b0, 0, 0);
    run_op("single_top", 2'd1, 1'b1, 'h7FFF, 'h7FFF, 32'h0, 1'b0, 0, 0);
    run_op("top_range", 2'd3, 1'b1, 'h7FF0, 'h7FFF, 32'h0F0F_3C3C, 1'b1, 'h7FFF, 'h7FFF);

    mode = 2'd0; verify = 1'b0; sa = AW'('h100); ea = AW'('h1FF); pattern = 32'hCAFE;
    start = 1'b1;
    repeat (5) step();
    chk("abort_pre_en", en_v, {NI{1'b1}});
    chk("abort_pre_addr", addr_v[0 +: AW], 'h104);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_state", {busy_v, en_v, done_v}, '0);
    en_any = 1'b0; done_any = 1'b0;
    repeat (10) begin
      step();
      en_any |= |en_v;
      done_any |= |done_v;
    end
    chk("abort_no_restart", {en_any, done_any}, '0);
    start = 1'b0;
    step();
    run_op("after_abort", 2'd2, 1'b0, 'h100, 'h10F, 32'h8000_0000, 1'b0, 0, 0);

    mode = 2'd2; verify = 1'b1; sa = AW'('h40); ea = AW'('h4F); pattern = 32'h55;
    start = 1'b1;
    repeat (19) step();
    chk("rd_pre_en", {en_v, wr_v}, {{NI{1'b1}}, {NI{1'b0}}});
    chk("rd_pre_addr", addr_v[0 +: AW], 'h42);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_rd_ctl", {en_v, wr_v, busy_v, done_v, err_v}, '0);
    chk("rst_rd_bus", {addr_v, err_addr_v, wdata_v}, '0);
    en_any = 1'b0; done_any = 1'b0;
    repeat (10) begin
      step();
      en_any |= |en_v;
      done_any |= |done_v;
    end
    chk("rst_no_resume", {en_any, done_any}, '0);
    start = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      s   = int'($urandom_range(0, 'h7FC0));
      len = int'($urandom_range(1, 40));
      run_op($sformatf("rand%0d", i), 2'(i), 1'($urandom), s, s + len - 1, $urandom,
             1'($urandom), s + int'($urandom_range(0, len - 1)),
             s + int'($urandom_range(0, len - 1)));
    end

    run_op("full", 2'd0, 1'b0, 0, 'h7FFF, 32'h0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
